// File: rtl/ysyx_23060332_mem_arbiter.sv
// ============================================================================
// Module   : ysyx_23060332_mem_arbiter
// Brief    : Shares one memory port between the IFU (read-only) and the LSU
//            (read/write). Only one transaction is in flight at a time.
//            Optional macro YSYX_23060332_ARB_RR_EN selects round-robin
//            arbitration. Without it, the LSU has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060332_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int MASK_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst_n,
   // IFU side
   input  logic              i_ifu_req_valid,
   output logic              o_ifu_req_ready,
   input  logic [ADDR_W-1:0] i_ifu_raddr,
   output logic              o_ifu_resp_valid,
   output logic [DATA_W-1:0] o_ifu_rdata,
   // LSU side
   input  logic              i_lsu_req_valid,
   output logic              o_lsu_req_ready,
   input  logic              i_lsu_wen,
   input  logic [ADDR_W-1:0] i_lsu_addr,
   input  logic [DATA_W-1:0] i_lsu_wdata,
   input  logic [MASK_W-1:0] i_lsu_wmask,
   output logic              o_lsu_resp_valid,
   output logic [DATA_W-1:0] o_lsu_rdata,
   // Memory side
   output logic              o_mem_req_valid,
   input  logic              i_mem_req_ready,
   output logic              o_mem_wen,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic [MASK_W-1:0] o_mem_wmask,
   input  logic              i_mem_resp_valid,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   localparam logic c_OWNER_IFU = 1'b0;
   localparam logic c_OWNER_LSU = 1'b1;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_owner;
   logic                r_wen;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [MASK_W-1:0]   r_wmask;

   logic                w_pick_lsu;
   logic                w_ifu_grant;
   logic                w_lsu_grant;
   logic                w_resp;

`ifdef YSYX_23060332_ARB_RR_EN
   logic                r_last_grant;

   // Round-robin: on a tie the requester not served last wins.
   always_comb begin
      w_pick_lsu = i_lsu_req_valid &&
                   (!i_ifu_req_valid || (r_last_grant == c_OWNER_IFU));
   end

   // Remember who was served by the most recent accepted request.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last_grant <= c_OWNER_LSU;
      end else if (w_lsu_grant) begin
         r_last_grant <= c_OWNER_LSU;
      end else if (w_ifu_grant) begin
         r_last_grant <= c_OWNER_IFU;
      end
   end
`else
   // Fixed priority: the LSU always wins when it is requesting.
   always_comb begin
      w_pick_lsu = i_lsu_req_valid;
   end
`endif

   // Handshakes only happen in IDLE and never while reset is held, so that
   // the ready outputs read as zero for the whole reset cycle.
   assign w_lsu_grant = rst_n && (r_state == S_IDLE) && w_pick_lsu;
   assign w_ifu_grant = rst_n && (r_state == S_IDLE) && i_ifu_req_valid && !w_pick_lsu;
   assign w_resp      = rst_n && (r_state == S_WAIT) && i_mem_resp_valid;

   // State register and latch of the granted request's fields.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_owner <= c_OWNER_IFU;
         r_wen   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wmask <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_lsu_grant) begin
            r_owner <= c_OWNER_LSU;
            r_wen   <= i_lsu_wen;
            r_addr  <= i_lsu_addr;
            r_wdata <= i_lsu_wdata;
            r_wmask <= i_lsu_wmask;
         end else if (w_ifu_grant) begin
            r_owner <= c_OWNER_IFU;
            r_wen   <= 1'b0;
            r_addr  <= i_ifu_raddr;
            r_wdata <= '0;
            r_wmask <= '0;
         end
      end
   end

   // Next-state logic and all combinational outputs.
   always_comb begin
      w_state_nxt      = r_state;
      o_ifu_req_ready  = w_ifu_grant;
      o_lsu_req_ready  = w_lsu_grant;
      o_mem_req_valid  = 1'b0;
      o_mem_wen        = 1'b0;
      o_mem_addr       = '0;
      o_mem_wdata      = '0;
      o_mem_wmask      = '0;
      o_ifu_resp_valid = 1'b0;
      o_ifu_rdata      = '0;
      o_lsu_resp_valid = 1'b0;
      o_lsu_rdata      = '0;

      case (r_state)
         S_IDLE: begin
            if (w_ifu_grant || w_lsu_grant) begin
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            // Memory fields come straight from the latch, so they stay
            // stable for as long as memory stalls.
            o_mem_req_valid = rst_n;
            if (rst_n) begin
               o_mem_wen   = r_wen;
               o_mem_addr  = r_addr;
               o_mem_wdata = r_wdata;
               o_mem_wmask = r_wmask;
            end
            if (i_mem_req_ready) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (w_resp) begin
               w_state_nxt = S_IDLE;
               if (r_owner == c_OWNER_LSU) begin
                  o_lsu_resp_valid = 1'b1;
                  o_lsu_rdata      = i_mem_rdata;
               end else begin
                  o_ifu_resp_valid = 1'b1;
                  o_ifu_rdata      = i_mem_rdata;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire
